pic_priority_isr: RTL and testbench

//  Stage downstream of the IRR: resolves the highest-priority unmasked pending request,

---
 rtl/pic_pkg.sv | 9 +
 rtl/pic_rot_prio_enc.sv | 20 ++
 rtl/pic_priority_isr.sv | 94 +++++++++
 tb/tb_pic_priority_isr.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared types, sizes and rotated-priority helper for the PIC priority/ISR stage
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam int LVL_W = 3;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl, input logic [LVL_W-1:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction
endpackage

// File: rtl/pic_rot_prio_enc.sv
// pic_rot_prio_enc: picks the highest-priority set bit, priority starting just above i_lowest
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] i_vec,
  input  logic [LVL_W-1:0]  i_lowest,
  output logic              o_valid,
  output logic [LVL_W-1:0]  o_lvl
);
  logic [LVL_W-1:0] w_idx;
  always_comb begin
    o_lvl = '0;
    w_idx = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      w_idx = i_lowest + LVL_W'(i) + 3'd1;
      if (i_vec[w_idx]) o_lvl = w_idx;
    end
  end
  assign o_valid = |i_vec;
endmodule

// File: rtl/pic_priority_isr.sv
// pic_priority_isr: priority resolver, INTA sequencer and in-service register of an 8-line PIC
// Defining PIC_AUTO_EOI_EN adds the aeoi input (ISR bit cleared at the end of the 2nd INTA).
module pic_priority_isr
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irr_in,
  input  logic [7:0] imr_in,
  input  logic       inta_n,
  input  logic       eoi_ns,
  input  logic       eoi_sp,
  input  logic [2:0] eoi_level,
  input  logic       rotate_en,
  input  logic [4:0] vector_base,
`ifdef PIC_AUTO_EOI_EN
  input  logic       aeoi,
`endif
  output logic       int_out,
  output logic [7:0] clear_irr,
  output logic [7:0] isr_out,
  output logic [7:0] data_out,
  output logic       data_oe
);
  state_t     r_state;
  logic [2:0] r_lowest, r_lvl;
  logic       r_inta_prev, r_int, r_oe;
  logic [7:0] r_isr, r_clr, r_dout;
  logic       w_cv, w_iv, w_ok, w_fall, w_rise, w_eoi, w_auto;
  logic [2:0] w_cl, w_il, w_eoi_lvl;
  logic [7:0] w_req, w_set, w_clr_mask;

  assign w_req = irr_in & ~imr_in;

  pic_rot_prio_enc u_req_enc (.i_vec(w_req), .i_lowest(r_lowest), .o_valid(w_cv), .o_lvl(w_cl));
  pic_rot_prio_enc u_isr_enc (.i_vec(r_isr), .i_lowest(r_lowest), .o_valid(w_iv), .o_lvl(w_il));

  // fully nested: a request must strictly outrank everything already in service
  assign w_ok = w_cv && (!w_iv || prio_rank(w_cl, r_lowest) < prio_rank(w_il, r_lowest));
  assign w_fall = r_inta_prev & ~inta_n;
  assign w_rise = ~r_inta_prev & inta_n;
  assign w_eoi = eoi_sp | (eoi_ns & w_iv);
  assign w_eoi_lvl = eoi_sp ? eoi_level : w_il;

`ifdef PIC_AUTO_EOI_EN
  logic r_spur;
  always_ff @(posedge clk)
    if (rst) r_spur <= 1'b0;
    else if (r_state == IDLE && w_fall) r_spur <= !w_ok;
  assign w_auto = aeoi && r_state == ACK2 && w_rise && !r_spur;
`else
  assign w_auto = 1'b0;
`endif

  assign w_set = (r_state == IDLE && w_fall && w_ok) ? 8'd1 << w_cl : 8'd0;
  assign w_clr_mask = (w_eoi ? 8'd1 << w_eoi_lvl : 8'd0) | (w_auto ? 8'd1 << r_lvl : 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lowest    <= 3'd7;
      r_lvl       <= 3'd7;
      r_inta_prev <= 1'b0;
      r_int       <= 1'b0;
      r_clr       <= '0;
      r_isr       <= '0;
      r_dout      <= '0;
      r_oe        <= 1'b0;
    end else begin
      r_inta_prev <= inta_n;
      r_int       <= w_ok && r_state == IDLE && !w_fall;
      r_clr       <= w_set;
      r_isr       <= (r_isr | w_set) & ~w_clr_mask;
      if (rotate_en && (w_eoi || w_auto)) r_lowest <= w_eoi ? w_eoi_lvl : r_lvl;
      if (r_state == IDLE && w_fall) begin
        r_state <= ACK1;
        r_lvl   <= w_ok ? w_cl : 3'd7;
      end else if (r_state == ACK1 && w_fall) begin
        r_state <= ACK2;
        r_dout  <= {vector_base, r_lvl};
        r_oe    <= 1'b1;
      end else if (r_state == ACK2 && w_rise) begin
        r_state <= IDLE;
        r_oe    <= 1'b0;
      end
    end
  end

  assign int_out   = r_int;
  assign clear_irr = r_clr;
  assign isr_out   = r_isr;
  assign data_out  = r_dout;
  assign data_oe   = r_oe;
endmodule

// File: tb/tb_pic_priority_isr.sv
// tb_pic_priority_isr: directed scenarios plus random traffic checked against a behavioural PIC model
module tb_pic_priority_isr;
  logic clk = 1'b0;
  logic rst, inta_n, eoi_ns, eoi_sp, rotate_en;
  logic [7:0] irr_in, imr_in;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic int_out, data_oe;
  logic [7:0] clear_irr, isr_out, data_out;
`ifdef PIC_AUTO_EOI_EN
  logic aeoi = 1'b0;
`endif

  always #5 clk = ~clk;

  pic_priority_isr dut (
    .clk(clk), .rst(rst), .irr_in(irr_in), .imr_in(imr_in), .inta_n(inta_n),
    .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_level(eoi_level), .rotate_en(rotate_en),
    .vector_base(vector_base),
`ifdef PIC_AUTO_EOI_EN
    .aeoi(aeoi),
`endif
    .int_out(int_out), .clear_irr(clear_irr), .isr_out(isr_out),
    .data_out(data_out), .data_oe(data_oe)
  );

  int vecs = 0, errs = 0;
  int m_low = 7, m_phase = 0, m_lvl = 7;
  logic m_prev = 1'b0, m_spur = 1'b0;
  logic [7:0] m_isr = '0, e_clr = '0, e_dout = '0;
  logic e_int = 1'b0, e_oe = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // rank 0 is the highest priority: the level just above the lowest one
  function automatic int rank(input int l);
    return (l - m_low + 15) % 8;
  endfunction

  function automatic int top_of(input logic [7:0] v);
    int best = -1;
    for (int l = 0; l < 8; l++)
      if (v[l] && (best < 0 || rank(l) < rank(best))) best = l;
    return best;
  endfunction

  task automatic model_edge();
    int c, t, ci;
    logic fall, rise, ok;
    if (rst) begin
      m_isr = '0; m_low = 7; m_phase = 0; m_lvl = 7; m_prev = 1'b0; m_spur = 1'b0;
      e_int = 1'b0; e_clr = '0; e_dout = '0; e_oe = 1'b0;
      return;
    end
    fall = m_prev && !inta_n;
    rise = !m_prev && inta_n;
    m_prev = inta_n;
    c = top_of(irr_in & ~imr_in);
    t = top_of(m_isr);
    ok = c >= 0 && (t < 0 || rank(c) < rank(t));
    e_int = ok && m_phase == 0 && !fall;
    e_clr = '0;
    ci = eoi_sp ? int'(eoi_level) : (eoi_ns ? t : -1);
    if (m_phase == 0 && fall) begin
      m_phase = 1;
      m_spur = !ok;
      m_lvl = ok ? c : 7;
      if (ok) begin
        m_isr[c] = 1'b1;
        e_clr[c] = 1'b1;
      end
    end else if (m_phase == 1 && fall) begin
      m_phase = 2;
      e_dout = {vector_base, 3'(m_lvl)};
      e_oe = 1'b1;
    end else if (m_phase == 2 && rise) begin
      m_phase = 0;
      e_oe = 1'b0;
`ifdef PIC_AUTO_EOI_EN
      if (aeoi && !m_spur) begin
        m_isr[m_lvl] = 1'b0;
        if (rotate_en && ci < 0) m_low = m_lvl;
      end
`endif
    end
    if (ci >= 0) begin
      m_isr[ci] = 1'b0;
      if (rotate_en) m_low = ci;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("int_out", {7'd0, int_out}, {7'd0, e_int});
    chk("clear_irr", clear_irr, e_clr);
    chk("isr_out", isr_out, m_isr);
    chk("data_out", data_out, e_dout);
    chk("data_oe", {7'd0, data_oe}, {7'd0, e_oe});
  endtask

  task automatic pulse();
    inta_n = 1'b0;
    step();
    irr_in &= ~e_clr;
    inta_n = 1'b1;
    step();
  endtask

  task automatic eoi_n();
    eoi_ns = 1'b1;
    step();
    eoi_ns = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inta_n = 1'b1; eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = '0;
    rotate_en = 1'b0; vector_base = 5'h08; irr_in = '0; imr_in = '0;
    step(); step();
    chk("reset_isr", isr_out, 8'h00);
    chk("reset_int", {7'd0, int_out}, 8'h00);
    rst = 1'b0;
    // basic two-pulse acknowledge of IR2
    irr_in = 8'h14;
    step();
    chk("t1_int", {7'd0, int_out}, 8'h01);
    inta_n = 1'b0;
    step();
    chk("t1_clr", clear_irr, 8'h04);
    chk("t1_isr", isr_out, 8'h04);
    chk("t1_int_drop", {7'd0, int_out}, 8'h00);
    irr_in = 8'h00;
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    chk("t1_vec", data_out, 8'h42);
    chk("t1_oe", {7'd0, data_oe}, 8'h01);
    inta_n = 1'b1; step();
    chk("t1_oe_off", {7'd0, data_oe}, 8'h00);
    // nesting: IR3 blocked by IR2 in service, IR0 gets through
    irr_in = 8'h08; step(); step();
    chk("t2_blocked", {7'd0, int_out}, 8'h00);
    irr_in = 8'h09; step();
    chk("t2_nested", {7'd0, int_out}, 8'h01);
    pulse(); pulse();
    chk("t2_isr", isr_out, 8'h05);
    eoi_n();
    chk("t2_eoi1", isr_out, 8'h04);
    eoi_n();
    chk("t2_eoi2", isr_out, 8'h00);
    irr_in = 8'h00; step(); step();
    // masking
    imr_in = 8'h04; irr_in = 8'h04; step();
    chk("t3_masked", {7'd0, int_out}, 8'h00);
    imr_in = 8'h00; step();
    chk("t3_unmasked", {7'd0, int_out}, 8'h01);
    irr_in = 8'h00; step();
    // rotation: servicing IR5 makes IR6 the highest priority
    rotate_en = 1'b1; irr_in = 8'h20; step();
    pulse(); pulse();
    chk("t4_isr", isr_out, 8'h20);
    eoi_n();
    chk("t4_eoi", isr_out, 8'h00);
    rotate_en = 1'b0; irr_in = 8'h41; step();
    inta_n = 1'b0; step();
    chk("t4_rot_clr", clear_irr, 8'h40);
    irr_in &= ~e_clr;
    inta_n = 1'b1; step();
    pulse();
    chk("t4_rot_vec", data_out, 8'h46);
    eoi_n();
    irr_in = 8'h00; step();
    // spurious: request withdrawn before the first acknowledge
    rst = 1'b1; step(); rst = 1'b0;
    irr_in = 8'h01; step();
    irr_in = 8'h00; inta_n = 1'b0; step();
    chk("t5_clr", clear_irr, 8'h00);
    chk("t5_isr", isr_out, 8'h00);
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    chk("t5_vec", data_out, 8'h47);
    inta_n = 1'b1; step();
    // reset in ACK1 with inta_n held low through the reset
    irr_in = 8'h02; step();
    inta_n = 1'b0; step();
    rst = 1'b1; step();
    chk("t6_int", {7'd0, int_out}, 8'h00);
    chk("t6_clr", clear_irr, 8'h00);
    chk("t6_isr", isr_out, 8'h00);
    chk("t6_dout", data_out, 8'h00);
    chk("t6_oe", {7'd0, data_oe}, 8'h00);
    rst = 1'b0; irr_in = 8'h00; step(); step();
    chk("t6_no_ack", isr_out, 8'h00);
    inta_n = 1'b1; step();
`ifdef PIC_AUTO_EOI_EN
    aeoi = 1'b1; irr_in = 8'h08; step();
    pulse(); pulse();
    chk("aeoi_isr", isr_out, 8'h00);
    aeoi = 1'b0; irr_in = 8'h00; step();
`endif
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      irr_in = (irr_in & ~e_clr) | (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      if ($urandom_range(0, 15) == 0) irr_in = 8'h00;
      if ($urandom_range(0, 31) == 0) imr_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, (e_int || m_phase != 0) ? 2 : 19) == 0) inta_n = ~inta_n;
      eoi_ns = $urandom_range(0, 9) == 0;
      eoi_sp = $urandom_range(0, 15) == 0;
      eoi_level = 3'($urandom);
      rotate_en = 1'($urandom);
      vector_base = 5'($urandom);
`ifdef PIC_AUTO_EOI_EN
      aeoi = 1'($urandom);
`endif
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
